ray_stepper_arbiter: RTL and testbench

Shares one ray stepper datapath between N ray requesters (e.g. per-pixel traversal units). Round-robin arbitration, operand capture and holding, start sequencing, completion detection and per-requester result return. An optional watchdog aborts stepper runs that never terminate.

---
 rtl/ray_stepper_arbiter_if.sv | 27 ++
 rtl/ray_stepper_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ray_stepper_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ray_stepper_arbiter_if.sv
// rtl/ray_stepper_arbiter_if.sv - requester/response bus between ray requesters and the stepper arbiter
interface ray_stepper_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N     = 4
);
  logic [N-1:0]                 reqValid;
  logic [N-1:0]                 reqReady;
  logic [N-1:0][2:0][WIDTH-1:0] reqQ;
  logic [N-1:0][2:0][WIDTH-1:0] reqV;
  logic [N-1:0][2:0][WIDTH-1:0] reqL;
  logic [N-1:0][2:0][WIDTH-1:0] reqU;
  logic [N-1:0]                 rspValid;
  logic [N-1:0]                 rspReady;
  logic [2:0][WIDTH-1:0]        rspQ;
  logic                         rspOutOfBounds;
  logic                         rspTimeout;

  modport master (
    output reqValid, reqQ, reqV, reqL, reqU, rspReady,
    input  reqReady, rspValid, rspQ, rspOutOfBounds, rspTimeout
  );

  modport slave (
    input  reqValid, reqQ, reqV, reqL, reqU, rspReady,
    output reqReady, rspValid, rspQ, rspOutOfBounds, rspTimeout
  );
endinterface

// File: rtl/ray_stepper_arbiter.sv
// rtl/ray_stepper_arbiter.sv - round-robin sharing of one ray stepper among N requesters
// Optional run watchdog enabled by defining RAY_ARB_WATCHDOG_EN.
module ray_stepper_arbiter #(
  parameter int WIDTH           = 16,
  parameter int N               = 4,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  ray_stepper_arbiter_if.slave  req,
  output logic                  busy,
  output logic                  stepReset,
  output logic                  stepStart,
  output logic [2:0][WIDTH-1:0] stepQ,
  output logic [2:0][WIDTH-1:0] stepV,
  output logic [2:0][WIDTH-1:0] stepL,
  output logic [2:0][WIDTH-1:0] stepU,
  input  logic                  stepDone,
  input  logic                  stepOutOfBounds,
  input  logic [2:0][WIDTH-1:0] stepQp
);
  localparam int IW = $clog2(N);

  if (N < 2 || N > 16 || WATCHDOG_CYCLES < 1) begin : g_param_check
    $error("ray_stepper_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t                state, state_next;
  logic [IW-1:0]         ptr, owner, winner;
  logic [2:0][WIDTH-1:0] op_q, op_v, op_l, op_u, rsp_q;
  logic                  rsp_oob;
  logic [N-1:0]          req_ready, rsp_valid;
  logic                  grant, complete, abort, wd_hit;

  // First pending requester after the last winner, wrapping at N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] valid, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx_v;
    logic          found;
    int            idx;
    pick  = '0;
    idx_v = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      idx_v = IW'(idx);
      if (!found && valid[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req.reqValid, ptr);

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    stepStart  = 1'b0;
    grant      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req.reqValid) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = S_START;
        end
      end
      S_START: begin
        stepStart  = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        // Completion takes priority over a coincident watchdog limit.
        if (stepDone) begin
          complete   = 1'b1;
          state_next = S_RESP;
        end else if (wd_hit) begin
          abort      = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner] = 1'b1;
        if (req.rspReady[owner]) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= IW'(N - 1);
      owner   <= '0;
      op_q    <= '0;
      op_v    <= '0;
      op_l    <= '0;
      op_u    <= '0;
      rsp_q   <= '0;
      rsp_oob <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        ptr   <= winner;
        owner <= winner;
        op_q  <= req.reqQ[winner];
        op_v  <= req.reqV[winner];
        op_l  <= req.reqL[winner];
        op_u  <= req.reqU[winner];
      end
      if (complete) begin
        rsp_q   <= stepQp;
        rsp_oob <= stepOutOfBounds;
      end else if (abort) begin
        rsp_q   <= stepQp;
        rsp_oob <= 1'b0;
      end
    end
  end

`ifdef RAY_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;
  logic           rsp_to;

  // Fires in the BUSY cycle that completes WATCHDOG_CYCLES cycles of waiting.
  assign wd_hit = (state == S_BUSY) && (wd_cnt == WDW'(WATCHDOG_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      rsp_to <= 1'b0;
    end else begin
      if (state == S_START) wd_cnt <= '0;
      else if (state == S_BUSY) wd_cnt <= wd_cnt + 1'b1;
      if (complete) rsp_to <= 1'b0;
      else if (abort) rsp_to <= 1'b1;
    end
  end

  assign req.rspTimeout = rsp_to;
`else
  assign wd_hit         = 1'b0;
  assign req.rspTimeout = 1'b0;
`endif

  assign req.reqReady       = req_ready;
  assign req.rspValid       = rsp_valid;
  assign req.rspQ           = rsp_q;
  assign req.rspOutOfBounds = rsp_oob;
  assign busy               = (state != S_IDLE);
  assign stepReset          = reset | abort;
  assign stepQ              = op_q;
  assign stepV              = op_v;
  assign stepL              = op_l;
  assign stepU              = op_u;
endmodule

// File: tb/tb_ray_stepper_arbiter.sv
// tb/tb_ray_stepper_arbiter.sv - scoreboard bench for ray_stepper_arbiter with a behavioural stepper
module tb_ray_stepper_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int WD = 64;

  typedef logic [2:0][W-1:0] vec_t;
  typedef struct {
    logic [N-1:0] owner_oh;
    vec_t         q;
    logic         oob;
    logic         to;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic busy, stepReset, stepStart, stepDone, stepOutOfBounds;
  vec_t stepQ, stepV, stepL, stepU, stepQp;

  ray_stepper_arbiter_if #(.WIDTH(W), .N(N)) bus ();

  ray_stepper_arbiter #(.WIDTH(W), .N(N), .WATCHDOG_CYCLES(WD)) dut (
    .clock(clock), .reset(reset), .req(bus), .busy(busy),
    .stepReset(stepReset), .stepStart(stepStart),
    .stepQ(stepQ), .stepV(stepV), .stepL(stepL), .stepU(stepU),
    .stepDone(stepDone), .stepOutOfBounds(stepOutOfBounds), .stepQp(stepQp)
  );

  always #5 clock = ~clock;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           grant_cyc = 0;
  int           start_cyc = 0;
  int           run_len = 4;
  logic         rsp_auto = 1'b1;
  logic [N-1:0] rsp_manual = '0;
  exp_t         exp_q[$];
  int           grant_log[$];
  vec_t         pay_q[N], pay_v[N], pay_l[N], pay_u[N], exp_qp[N];
  logic         exp_oob[N];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic vec_t vec(input int x, input int y, input int z);
    return {W'(z), W'(y), W'(x)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input int i);
    bus.reqQ[i] = pay_q[i];
    bus.reqV[i] = pay_v[i];
    bus.reqL[i] = pay_l[i];
    bus.reqU[i] = pay_u[i];
  endtask

  task automatic push(input int i, input vec_t q, input logic oob, input logic to);
    exp_t e;
    e.owner_oh    = '0;
    e.owner_oh[i] = 1'b1;
    e.q           = q;
    e.oob         = oob;
    e.to          = to;
    exp_q.push_back(e);
  endtask

  task automatic await_grant(input int i);
    int k;
    k = 0;
    @(negedge clock); #2;
    while (!bus.reqReady[i] && k < 300) begin
      @(negedge clock); #2;
      k++;
    end
    if (!bus.reqReady[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: requester %0d never granted, reqReady=%b", i, bus.reqReady);
    end
    step(1);
  endtask

  task automatic await_rsp();
    int k;
    k = 0;
    @(negedge clock); #2;
    while (bus.rspValid == '0 && k < 300) begin
      @(negedge clock); #2;
      k++;
    end
    if (bus.rspValid == '0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait_timeout: rspValid=%b", bus.rspValid);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clock); #2;
    while ((exp_q.size() != 0 || busy) && k < 2000) begin
      @(negedge clock); #2;
      k++;
    end
    if (exp_q.size() != 0 || busy) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, busy=%b", exp_q.size(), busy);
    end
    step(1);
  endtask

  task automatic check_rst(input string tag, input logic sr);
    @(negedge clock); #2;
    check({tag, "_reqReady"}, bus.reqReady, '0);
    check({tag, "_rspValid"}, bus.rspValid, '0);
    check({tag, "_rspQ"}, bus.rspQ, '0);
    check({tag, "_rspFlags"}, {bus.rspOutOfBounds, bus.rspTimeout}, 2'b00);
    check({tag, "_busy_start"}, {busy, stepStart}, 2'b00);
    check({tag, "_stepReset"}, stepReset, sr);
    check({tag, "_stepQV"}, {stepQ, stepV}, '0);
    check({tag, "_stepLU"}, {stepL, stepU}, '0);
    step(1);
  endtask

  // Behavioural stepper: latches q/v on start, done falls after the start
  // cycle, runs run_len cycles, then reports the exit face position.
  initial begin
    vec_t s_q, s_v, m_q, m_v;
    logic s_rst, s_start, m_run;
    int   m_cnt;
    stepDone = 1'b1; stepOutOfBounds = 1'b0; stepQp = '0;
    m_q = '0; m_v = '0; m_run = 1'b0; m_cnt = 0;
    forever begin
      @(negedge clock);
      s_rst = stepReset; s_start = stepStart; s_q = stepQ; s_v = stepV;
      @(posedge clock); #1;
      if (s_rst) begin
        stepDone = 1'b1;
        m_run    = 1'b0;
      end else if (s_start) begin
        m_q = s_q; m_v = s_v;
        stepDone = 1'b0; stepQp = s_q;
        m_cnt = run_len; m_run = 1'b1;
      end else if (m_run && m_v != '0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          stepDone = 1'b1; m_run = 1'b0; stepOutOfBounds = 1'b0;
          for (int a = 0; a < 3; a++) begin
            if ($signed(m_v[a]) > 0) stepQp[a] = stepU[a] + W'(1);
            else if ($signed(m_v[a]) < 0) begin
              stepQp[a] = stepL[a] - W'(1);
              stepOutOfBounds = 1'b1;
            end else stepQp[a] = m_q[a];
          end
        end
      end
    end
  end

  initial begin
    bus.rspReady = '0;
    forever begin
      @(negedge clock);
      bus.rspReady = rsp_auto ? bus.rspValid : rsp_manual;
    end
  end

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t         e;
    logic [N-1:0] prev_rv;
    prev_rv = '0;
    forever begin
      @(negedge clock); #1;
      if (bus.rspValid != '0 && prev_rv == '0 && !bus.rspTimeout)
        check("rsp_latency", cyc - grant_cyc, 3 + run_len);
      if (bus.rspValid != '0) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_spurious: rspValid=%b with no ray outstanding", bus.rspValid);
        end else if ((bus.rspValid & bus.rspReady) != '0) begin
          e = exp_q.pop_front();
          check("rsp_owner", bus.rspValid, e.owner_oh);
          check("rsp_q", bus.rspQ, e.q);
          check("rsp_oob", bus.rspOutOfBounds, e.oob);
          check("rsp_timeout", bus.rspTimeout, e.to);
        end
      end
      prev_rv = bus.rspValid;
    end
  end

  initial begin
    forever begin
      @(negedge clock); #1;
      if (bus.reqReady != '0) begin
        check("grant_onehot_idle", {busy, $countones(bus.reqReady) == 1}, 2'b01);
        grant_cyc = cyc;
        for (int i = 0; i < N; i++) if (bus.reqReady[i]) grant_log.push_back(i);
      end
      if (stepStart) begin
        check("start_latency", cyc - grant_cyc, 1);
        start_cyc = cyc;
      end
      if (stepReset && !reset) check("wd_pulse_cycle", cyc - start_cyc, WD);
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base, k, g;
    pay_q[0] = vec(10, 10, 10);    pay_v[0] = vec(200, 0, 0);  pay_l[0] = vec(0, 0, 0);
    pay_u[0] = vec(255, 255, 255); exp_qp[0] = vec(256, 10, 10); exp_oob[0] = 1'b0;
    pay_q[1] = vec(30, 40, 50);    pay_v[1] = vec(0, -3, 0);   pay_l[1] = vec(0, 10, 0);
    pay_u[1] = vec(99, 99, 99);    exp_qp[1] = vec(30, 9, 50);   exp_oob[1] = 1'b1;
    pay_q[2] = vec(7, 8, 9);       pay_v[2] = vec(0, 0, 1);    pay_l[2] = vec(0, 0, 0);
    pay_u[2] = vec(100, 100, 300); exp_qp[2] = vec(7, 8, 301);   exp_oob[2] = 1'b0;
    pay_q[3] = vec(500, 600, 700); pay_v[3] = vec(-1, 2, 0);   pay_l[3] = vec(100, 0, 0);
    pay_u[3] = vec(999, 900, 999); exp_qp[3] = vec(99, 901, 700); exp_oob[3] = 1'b1;
    for (int i = 0; i < N; i++) load(i);
    bus.reqValid = '0;
    reset = 1'b1;

    step(2);
    check_rst("rst", 1'b1);
    reset = 1'b0;
    check_rst("rst_rel", 1'b0);

    // Single ray on requester 0.
    run_len = 4;
    push(0, exp_qp[0], exp_oob[0], 1'b0);
    bus.reqValid[0] = 1'b1;
    await_grant(0);
    bus.reqValid[0] = 1'b0;
    drain();

    // Contention from a fresh reset: all four held high for five grants.
    reset = 1'b1; step(2); reset = 1'b0; step(1);
    run_len = 3;
    for (int i = 0; i < 5; i++) push(i % N, exp_qp[i % N], exp_oob[i % N], 1'b0);
    base = grant_log.size();
    bus.reqValid = '1;
    k = 0;
    @(negedge clock); #2;
    while (grant_log.size() < base + 5 && k < 500) begin
      @(negedge clock); #2;
      k++;
    end
    step(1);
    bus.reqValid = '0;
    drain();
    for (int i = 0; i < 5; i++) begin
      g = (grant_log.size() > base + i) ? grant_log[base + i] : -1;
      check("contention_order", g, i % N);
    end

    // Backpressure: owner 2 stalled 20 cycles while requester 1 waits.
    run_len = 2;
    rsp_auto = 1'b0; rsp_manual = '0;
    push(2, exp_qp[2], exp_oob[2], 1'b0);
    bus.reqValid[2] = 1'b1;
    await_grant(2);
    bus.reqValid[2] = 1'b0;
    push(1, exp_qp[1], exp_oob[1], 1'b0);
    bus.reqValid[1] = 1'b1;
    await_rsp();
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {bus.rspValid, bus.rspQ, bus.reqReady}, {4'b0100, exp_qp[2], 4'b0000});
      @(negedge clock); #2;
    end
    step(1);
    rsp_manual = 4'b0100;
    step(1);
    rsp_auto = 1'b1; rsp_manual = '0;
    @(negedge clock); #2;
    check("bp_release", {busy, bus.rspValid, bus.reqReady}, {1'b0, 4'b0000, 4'b0010});
    step(1);
    bus.reqValid[1] = 1'b0;
    drain();

    // Ready on a non-owner only must not release the response.
    rsp_auto = 1'b0; rsp_manual = 4'b0001;
    push(3, exp_qp[3], exp_oob[3], 1'b0);
    bus.reqValid[3] = 1'b1;
    await_grant(3);
    bus.reqValid[3] = 1'b0;
    await_rsp();
    for (int i = 0; i < 3; i++) begin
      check("nonowner_hold", {busy, bus.rspValid}, {1'b1, 4'b1000});
      @(negedge clock); #2;
    end
    step(1);
    rsp_manual = 4'b1000;
    step(1);
    rsp_auto = 1'b1; rsp_manual = '0;
    drain();

    // Reset five cycles into BUSY; the aborted ray must never respond.
    run_len = 20;
    bus.reqValid[1] = 1'b1;
    await_grant(1);
    bus.reqValid[1] = 1'b0;
    step(5);
    reset = 1'b1;
    step(1);
    check_rst("midrst", 1'b1);
    reset = 1'b0;
    check_rst("midrst_rel", 1'b0);
    run_len = 3;
    base = grant_log.size();
    push(0, exp_qp[0], exp_oob[0], 1'b0);
    push(2, exp_qp[2], exp_oob[2], 1'b0);
    bus.reqValid[0] = 1'b1; bus.reqValid[2] = 1'b1;
    await_grant(0);
    bus.reqValid[0] = 1'b0;
    await_grant(2);
    bus.reqValid[2] = 1'b0;
    drain();
    g = (grant_log.size() > base) ? grant_log[base] : -1;
    check("rst_next_grant", g, 0);

`ifdef RAY_ARB_WATCHDOG_EN
    // Stalled run (zero direction) is aborted; a normal ray follows.
    bus.reqQ[0] = vec(10, 10, 10);
    bus.reqV[0] = '0;
    push(0, vec(10, 10, 10), 1'b0, 1'b1);
    bus.reqValid[0] = 1'b1;
    await_grant(0);
    bus.reqValid[0] = 1'b0;
    drain();
    load(0);
    push(1, exp_qp[1], exp_oob[1], 1'b0);
    bus.reqValid[1] = 1'b1;
    await_grant(1);
    bus.reqValid[1] = 1'b0;
    drain();
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
